// File: rtl/scene_if.sv
// Control and status bundle between the frame timing side and the scene sequencer.
// frame_done is a one-cycle valid pulse with no ready: the sequencer cannot stall the timing generator.
interface scene_if #(
  parameter int SCENE_W = 2
);
  logic               frame_done;
  logic               pause;
  logic               skip;
  logic [SCENE_W-1:0] scene_id;
  logic [1:0]         fade;
  logic [9:0]         scene_frame;
  logic [15:0]        global_frame;
  logic               in_transition;
  logic               update;
  logic [1:0]         dbg_state;

  modport master (
    output frame_done, pause, skip,
    input  scene_id, fade, scene_frame, global_frame, in_transition, update, dbg_state
  );

  modport slave (
    input  frame_done, pause, skip,
    output scene_id, fade, scene_frame, global_frame, in_transition, update, dbg_state
  );
endinterface

// File: rtl/scene_sequencer.sv
// Frame-rate scene scheduler: fades each effect in, holds it, fades it out and
// advances scene_id only while black. All outputs move on accepted frame ticks.
module scene_sequencer #(
  parameter int NUM_SCENES  = 4,
  parameter int FADE_STEP   = 4,
  parameter int HOLD_FRAMES = 240,
  parameter int SCENE_W     = $clog2(NUM_SCENES)
) (
  input logic    clk,
  input logic    rst_n,
  scene_if.slave bus
);
  localparam int STEP_W = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(FADE_STEP - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    FADE_IN  = 2'd0,
    HOLD     = 2'd1,
    FADE_OUT = 2'd2,
    BLACK    = 2'd3
  } state_t;

  state_t              state;
  logic [STEP_W-1:0]   step_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                skip_pend;
  logic                acc;
  logic                skip_hit;
  logic                counting;

  assign acc      = bus.frame_done & ~bus.pause;
  assign skip_hit = skip_pend | bus.skip;
  assign counting = (state == FADE_IN) || (state == HOLD) || (state == FADE_OUT);
  assign bus.dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= FADE_IN;
      step_cnt          <= '0;
      hold_cnt          <= '0;
      skip_pend         <= 1'b0;
      bus.scene_id      <= '0;
      bus.fade          <= 2'd0;
      bus.scene_frame   <= 10'd0;
      bus.global_frame  <= 16'd0;
      bus.in_transition <= 1'b1;
      bus.update        <= 1'b0;
    end else begin
      bus.update <= acc;
      if (!acc) begin
        // A skip seen between ticks (including while paused) waits for the next tick.
        if (bus.skip) skip_pend <= 1'b1;
      end else begin
        skip_pend        <= 1'b0;
        bus.global_frame <= bus.global_frame + 16'd1;
        if (counting && bus.scene_frame != 10'd1023)
          bus.scene_frame <= bus.scene_frame + 10'd1;
        case (state)
          FADE_IN: begin
            if (skip_hit) begin
              state             <= FADE_OUT;
              step_cnt          <= '0;
              bus.in_transition <= 1'b1;
            end else if (step_cnt == LAST_STEP) begin
              step_cnt <= '0;
              bus.fade <= bus.fade + 2'd1;
              if (bus.fade == 2'd2) begin
                state             <= HOLD;
                hold_cnt          <= '0;
                bus.in_transition <= 1'b0;
              end
            end else begin
              step_cnt <= step_cnt + STEP_W'(1);
            end
          end
          HOLD: begin
            if (skip_hit || hold_cnt == LAST_HOLD) begin
              state             <= FADE_OUT;
              step_cnt          <= '0;
              bus.in_transition <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          FADE_OUT: begin
            // A skip taken at fade 0 must not wrap brightness back to full.
            if (step_cnt == LAST_STEP) begin
              step_cnt <= '0;
              if (bus.fade <= 2'd1) begin
                bus.fade <= 2'd0;
                state    <= BLACK;
              end else begin
                bus.fade <= bus.fade - 2'd1;
              end
            end else begin
              step_cnt <= step_cnt + STEP_W'(1);
            end
          end
          BLACK: begin
            bus.scene_id      <= bus.scene_id + SCENE_W'(1);
            bus.scene_frame   <= 10'd0;
            step_cnt          <= '0;
            state             <= FADE_IN;
            bus.in_transition <= 1'b1;
          end
          default: begin
            state             <= BLACK;
            bus.in_transition <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/scene_sequencer.md
# scene_sequencer

Frame-rate scheduler for the demo. It consumes the one-cycle end-of-frame pulse from the VGA timing generator and decides which effect generator owns the RGB output mux (`scene_id`). It also drives a 2-bit global brightness (`fade`) that ramps each scene in and out, and switches scenes only while the screen is black and on a frame boundary. All outputs are registered and change only on accepted frame ticks, so downstream effects see stable values for a whole frame.

## Interface
- `NUM_SCENES`, 4: number of effect scenes; power of two, ≥2. `SCENE_W = $clog2(NUM_SCENES)`.
- `FADE_STEP`, 4: accepted frames per fade level step; ≥1.
- `HOLD_FRAMES`, 240: accepted frames spent at full brightness per scene; ≥1.
- `clk  in  1`: pixel clock.
- `rst_n  in  1`: reset, synchronous, active-low.
- `frame_done  in  1`: one-cycle pulse from the timing generator at the end of vertical back porch.
- `pause  in  1`: level. While high, `frame_done` is ignored and all counters freeze.
- `skip  in  1`: one-cycle pulse requesting an early fade-out of the current scene.
- `scene_id  out  SCENE_W`: selects the effect driving the RGB mux.
- `fade  out  2`: brightness; 0 is black, 3 is full.
- `scene_frame  out  10`: accepted frames since the scene started; saturates at 1023.
- `global_frame  out  16`: accepted frames since reset; wraps at 65535→0.
- `in_transition  out  1`: high in every state except HOLD.
- `update  out  1`: one-cycle pulse marking the cycle in which the outputs first show new values.

## Operation
- Accepted tick (`acc`) = `frame_done & ~pause`. All state advances only on `acc`.
- States: FADE_IN, HOLD, FADE_OUT, BLACK.
- Internal counters:
  - `step_cnt` (counts 0..FADE_STEP-1), used in the fade states.
  - `hold_cnt` (counts 0..HOLD_FRAMES-1).
  - `skip_pend` flag.
- FADE_IN, on `acc`:
  - If `step_cnt==FADE_STEP-1`: `step_cnt<=0` and `fade<=fade+1`. If the new fade is 3, go to HOLD with `hold_cnt<=0`.
  - Otherwise: `step_cnt<=step_cnt+1`.
- HOLD, on `acc`:
  - If `hold_cnt==HOLD_FRAMES-1`: go to FADE_OUT with `step_cnt<=0`.
  - Otherwise: `hold_cnt+1`.
- FADE_OUT, on `acc`: same step rule as FADE_IN, but `fade<=fade-1`. When the new fade is 0, go to BLACK.
- BLACK, on `acc`:
  - `scene_id<=scene_id+1` (NUM_SCENES-1 wraps to 0).
  - `scene_frame<=0`, `step_cnt<=0`, go to FADE_IN. `fade` stays 0.
- `scene_frame` increments (saturating) on `acc` in FADE_IN, HOLD and FADE_OUT. `global_frame` increments on every `acc`.
- Skip handling:
  - A `skip` pulse sets `skip_pend`. A pulse arriving while paused is held until the first `acc` after release.
  - On `acc` with `skip_pend` (or with `skip` in the same cycle) in FADE_IN or HOLD: go to FADE_OUT, `step_cnt<=0`, `fade` unchanged on that tick, clear `skip_pend`.
  - In FADE_OUT or BLACK, `skip_pend` is cleared on `acc` with no effect.
- `in_transition` is registered from the next state.
- Illegal state encoding: go to BLACK on the next `acc`; outputs are otherwise held.

## Timing
- Reset values:
  - State FADE_IN.
  - `scene_id`=0, `fade`=0, `scene_frame`=0, `global_frame`=0, `in_transition`=1, `update`=0.
  - `step_cnt`=0, `hold_cnt`=0, `skip_pend`=0.
- Latency:
  - Outputs change on the clk edge that samples `acc`.
  - `update` is high for exactly the following cycle, the first cycle showing the new values.
  - No output changes on non-`acc` cycles, except that `skip_pend` is internal.
- Rate: at most one state step per `acc`. Back-to-back `frame_done` pulses on consecutive cycles are each accepted.
- Reset dominates: with `rst_n=0`, a `frame_done` or `skip` in the same cycle is discarded.
- `pause` asserted in the same cycle as `frame_done`: the tick is dropped and `update` stays 0.
- Defaults (FADE_STEP=4, HOLD_FRAMES=240), counting `acc` ticks from reset:
  - `fade`=1 after tick 4, 2 after tick 8, 3 after tick 12, entering HOLD.
  - FADE_OUT entered at tick 252.
  - `fade`=2 at 256, 1 at 260, 0 at 264, entering BLACK.
  - `scene_id`=1 at tick 265.
  - Full scene period is 265 ticks.

## Test plan
- Reset, then 265 `frame_done` pulses → `fade` steps 0→1→2→3 at ticks 4/8/12 and 3→2→1→0 at 256/260/264; `scene_id`=1 after tick 265; `scene_frame`=0 and `global_frame`=265.
- Run 4×265 ticks → `scene_id` sequence 0,1,2,3,0. Each `scene_id` change occurs only while `fade`=0. `update` pulses exactly once per tick.
- `skip` at HOLD tick 50 → the next `acc` enters FADE_OUT with `fade` still 3; `fade` reaches 0 four ticks per level later; `skip` in BLACK → no effect.
- `pause` high for 100 `frame_done` pulses mid-HOLD, with `skip` pulsed during the pause → no output change and no `update`; the first tick after release enters FADE_OUT.
- `frame_done` and `pause` in the same cycle, then `frame_done` alone → only the second tick is counted. `rst_n`=0 at tick 130 → all outputs return to reset values on the next edge.
- `scene_frame` saturation with HOLD_FRAMES=1100 → holds at 1023. `global_frame` with 65536 ticks → wraps to 0.
